// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter mux.
package rr_arb_pkg;

    localparam int unsigned N_REQ = 4;

    typedef logic [1:0] req_idx_t;

    // Advance a requester index by one; 2-bit arithmetic makes 3 wrap to 0.
    function automatic req_idx_t next_idx(input req_idx_t idx);
        return req_idx_t'(idx + 2'd1);
    endfunction

endpackage

// File: rtl/mux_4_1.sv
// Plain 4:1 data multiplexer.
module mux_4_1 #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    input  logic [1:0]   sel,
    output logic [W-1:0] y
);

    always_comb begin
        y = d0;
        unique case (sel)
            2'd0: y = d0;
            2'd1: y = d1;
            2'd2: y = d2;
            2'd3: y = d3;
            default: y = d0;
        endcase
    end

endmodule

// File: rtl/rr_pick_4.sv
// Combinational round-robin pick: first valid requester at or after ptr.
module rr_pick_4
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] vld,
    input  req_idx_t         ptr,
    output logic             any,
    output req_idx_t         grant
);

    req_idx_t idx;

    always_comb begin
        any   = 1'b0;
        grant = ptr;
        idx   = ptr;
        for (int k = 0; k < int'(N_REQ); k++) begin
            idx = req_idx_t'(ptr + req_idx_t'(k));
            if (!any && vld[idx]) begin
                any   = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux_4_1.sv
// Round-robin arbiter feeding a shared 4:1 mux into a one-deep registered output stage.
// Optional per-requester saturating grant counters: define RR_ARB_GRANT_CNT_EN.
module rr_arb_mux_4_1
    import rr_arb_pkg::*;
#(
    parameter int unsigned W     = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     d0,
    input  logic [W-1:0]     d1,
    input  logic [W-1:0]     d2,
    input  logic [W-1:0]     d3,
    input  logic [N_REQ-1:0] vld,
    output logic [N_REQ-1:0] rdy,
    output logic [W-1:0]     out_data,
    output logic [1:0]       out_sel,
    output logic             out_vld,
    input  logic             out_rdy
`ifdef RR_ARB_GRANT_CNT_EN
    ,
    output logic [CNT_W-1:0] gnt_cnt [N_REQ]
`endif
);

    req_idx_t     ptr;
    req_idx_t     grant;
    logic         any;
    logic         can_load;
    logic [W-1:0] sel_data;

    rr_pick_4 u_pick (
        .vld   (vld),
        .ptr   (ptr),
        .any   (any),
        .grant (grant)
    );

    mux_4_1 #(.W(W)) u_mux (
        .d0  (d0),
        .d1  (d1),
        .d2  (d2),
        .d3  (d3),
        .sel (grant),
        .y   (sel_data)
    );

    assign can_load = !out_vld || out_rdy;

    // No handshake is offered while reset is asserted, since that word would be discarded.
    assign rdy = (!rst && can_load && any) ? 4'(4'b0001 << grant) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            out_sel  <= '0;
            ptr      <= '0;
        end else if (can_load) begin
            if (any) begin
                out_data <= sel_data;
                out_sel  <= grant;
                out_vld  <= 1'b1;
                ptr      <= next_idx(grant);
            end else begin
                out_vld  <= 1'b0;
            end
        end
    end

`ifdef RR_ARB_GRANT_CNT_EN
    // Saturating count of accepted transfers per requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(N_REQ); i++) gnt_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (rdy[i] && (gnt_cnt[i] != '1)) gnt_cnt[i] <= gnt_cnt[i] + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// Directed self-checking bench for rr_arb_mux_4_1.
module tb_rr_arb_mux_4_1;

    localparam int unsigned W     = 4;
    localparam int unsigned CNT_W = 2;

    logic         clk;
    logic         rst;
    logic [W-1:0] d0, d1, d2, d3;
    logic [3:0]   vld;
    logic [3:0]   rdy;
    logic [W-1:0] out_data;
    logic [1:0]   out_sel;
    logic         out_vld;
    logic         out_rdy;
`ifdef RR_ARB_GRANT_CNT_EN
    logic [CNT_W-1:0] gnt_cnt [4];
`endif

    int checks = 0;
    int errors = 0;

    rr_arb_mux_4_1 #(.W(W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .d0       (d0),
        .d1       (d1),
        .d2       (d2),
        .d3       (d3),
        .vld      (vld),
        .rdy      (rdy),
        .out_data (out_data),
        .out_sel  (out_sel),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy)
`ifdef RR_ARB_GRANT_CNT_EN
        ,
        .gnt_cnt  (gnt_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge, then settle 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; vld = 4'hF; out_rdy = 1'b1;
        d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4;
        step();
        step();
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld got %b want 0", out_vld); end
        checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL reset_out_sel got %0d want 0", out_sel); end
        checks++; if (out_data !== 4'd0) begin errors++; $display("FAIL reset_out_data got %0d want 0", out_data); end
        checks++; if (rdy !== 4'b0000) begin errors++; $display("FAIL reset_rdy got %b want 0000", rdy); end
`ifdef RR_ARB_GRANT_CNT_EN
        for (int i = 0; i < 4; i++) begin
            checks++; if (gnt_cnt[i] !== '0) begin errors++; $display("FAIL reset_gnt_cnt%0d got %0d want 0", i, gnt_cnt[i]); end
        end
`endif
        rst = 1'b0;
    endtask

    // ptr=0 entering; leaves ptr=1 and stage empty.
    task automatic test_rotation();
        logic [3:0] exp_rdy  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [3:0] exp_data [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1};
        logic [1:0] exp_sel  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        vld = 4'hF; out_rdy = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (rdy !== exp_rdy[c]) begin errors++; $display("FAIL rot_rdy c%0d got %b want %b", c, rdy, exp_rdy[c]); end
            step();
            checks++; if (out_vld !== 1'b1 || out_data !== exp_data[c] || out_sel !== exp_sel[c]) begin
                errors++; $display("FAIL rot_out c%0d got vld=%b data=%0d sel=%0d want vld=1 data=%0d sel=%0d",
                                   c, out_vld, out_data, out_sel, exp_data[c], exp_sel[c]);
            end
        end
        vld = 4'h0;
        step();
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL rot_drain got %b want 0", out_vld); end
    endtask

    // ptr=1 entering with vld=1001: grant 3, then 0; leaves ptr=1.
    task automatic test_ptr_skip();
        vld = 4'b1001; out_rdy = 1'b1;
        #1;
        checks++; if (rdy !== 4'b1000) begin errors++; $display("FAIL skip_rdy0 got %b want 1000", rdy); end
        step();
        checks++; if (out_sel !== 2'd3 || out_data !== 4'd4) begin errors++; $display("FAIL skip_out0 got sel=%0d data=%0d want sel=3 data=4", out_sel, out_data); end
        checks++; if (rdy !== 4'b0001) begin errors++; $display("FAIL skip_rdy1 got %b want 0001", rdy); end
        step();
        checks++; if (out_sel !== 2'd0 || out_data !== 4'd1) begin errors++; $display("FAIL skip_out1 got sel=%0d data=%0d want sel=0 data=1", out_sel, out_data); end
        vld = 4'h0;
        step();
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL skip_drain got %b want 0", out_vld); end
    endtask

    // ptr=1 entering; leaves ptr=3.
    task automatic test_backpressure();
        vld = 4'hF; out_rdy = 1'b1;
        #1;
        checks++; if (rdy !== 4'b0010) begin errors++; $display("FAIL bp_rdy_first got %b want 0010", rdy); end
        step();
        out_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (rdy !== 4'b0000) begin errors++; $display("FAIL bp_rdy_stall c%0d got %b want 0000", c, rdy); end
            step();
            checks++; if (out_vld !== 1'b1 || out_data !== 4'd2 || out_sel !== 2'd1) begin
                errors++; $display("FAIL bp_hold c%0d got vld=%b data=%0d sel=%0d want vld=1 data=2 sel=1", c, out_vld, out_data, out_sel);
            end
        end
        out_rdy = 1'b1;
        #1;
        checks++; if (rdy !== 4'b0100) begin errors++; $display("FAIL bp_rdy_release got %b want 0100", rdy); end
        step();
        checks++; if (out_vld !== 1'b1 || out_data !== 4'd3 || out_sel !== 2'd2) begin
            errors++; $display("FAIL bp_next got vld=%b data=%0d sel=%0d want vld=1 data=3 sel=2", out_vld, out_data, out_sel);
        end
        vld = 4'h0;
        step();
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", out_vld); end
    endtask

    // ptr=3 entering; single word from requester 0 moves ptr to 1, idle must not move it.
    task automatic test_idle_drain();
        vld = 4'b0001; out_rdy = 1'b1;
        #1;
        checks++; if (rdy !== 4'b0001) begin errors++; $display("FAIL idle_rdy got %b want 0001", rdy); end
        step();
        checks++; if (out_vld !== 1'b1 || out_data !== 4'd1 || out_sel !== 2'd0) begin
            errors++; $display("FAIL idle_word got vld=%b data=%0d sel=%0d want vld=1 data=1 sel=0", out_vld, out_data, out_sel);
        end
        vld = 4'h0;
        step();
        checks++; if (out_vld !== 1'b0 || out_data !== 4'd1 || out_sel !== 2'd0) begin
            errors++; $display("FAIL idle_fall got vld=%b data=%0d sel=%0d want vld=0 data=1 sel=0", out_vld, out_data, out_sel);
        end
        step();
        step();
        vld = 4'hF;
        #1;
        checks++; if (rdy !== 4'b0010) begin errors++; $display("FAIL idle_ptr_hold got %b want 0010", rdy); end
        step();
        checks++; if (out_sel !== 2'd1) begin errors++; $display("FAIL idle_next_sel got %0d want 1", out_sel); end
    endtask

    // Held word under backpressure is discarded by reset; ptr returns to 0.
    task automatic test_reset_mid();
        vld = 4'h0; out_rdy = 1'b0;
        step();
        checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL mid_held got %b want 1", out_vld); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (out_vld !== 1'b0 || out_data !== 4'd0 || out_sel !== 2'd0) begin
            errors++; $display("FAIL mid_reset got vld=%b data=%0d sel=%0d want 0/0/0", out_vld, out_data, out_sel);
        end
        vld = 4'hF; out_rdy = 1'b1;
        #1;
        checks++; if (rdy !== 4'b0001) begin errors++; $display("FAIL mid_ptr got %b want 0001", rdy); end
        vld = 4'h0;
        step();
        step();
    endtask

`ifdef RR_ARB_GRANT_CNT_EN
    task automatic test_grant_cnt();
        logic [CNT_W-1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        rst = 1'b1; vld = 4'h0; out_rdy = 1'b1;
        step();
        rst = 1'b0;
        vld = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++; if (gnt_cnt[0] !== exp_cnt[c]) begin errors++; $display("FAIL cnt0 c%0d got %0d want %0d", c, gnt_cnt[0], exp_cnt[c]); end
        end
        checks++; if (gnt_cnt[1] !== '0) begin errors++; $display("FAIL cnt1 got %0d want 0", gnt_cnt[1]); end
        vld = 4'h0;
        step();
    endtask
`endif

    initial begin
        rst = 1'b1; vld = 4'h0; out_rdy = 1'b0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        test_reset();
        test_rotation();
        test_ptr_skip();
        test_backpressure();
        test_idle_drain();
        test_reset_mid();
`ifdef RR_ARB_GRANT_CNT_EN
        test_grant_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
